// File: rtl/ac_motor_pkg.sv
// Shared types and default sizing for the N-phase PWM dead-time stage.
package ac_motor_pkg;

    localparam int N_PH_DEF = 3;
    localparam int DW_DEF   = 24;
    localparam int DT_W_DEF = 11;

    typedef enum logic [2:0] {
        OFF    = 3'd0,
        LO_ON  = 3'd1,
        DEAD_H = 3'd2,
        HI_ON  = 3'd3,
        DEAD_L = 3'd4
    } ph_state_t;

endpackage

// File: rtl/ac_motor_deadtime_ch.sv
// One phase of the gate driver: complementary hi/lo outputs with dead-time insertion.
//
//  state  | meaning
//  OFF    | gates disabled, both outputs low
//  LO_ON  | low-side gate on
//  DEAD_H | both off, waiting to turn high side on
//  HI_ON  | high-side gate on
//  DEAD_L | both off, waiting to turn low side on
module ac_motor_deadtime_ch
    import ac_motor_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            raw,
    input  logic [DT_W-1:0] dt,
    output logic            hi,
    output logic            lo
);

    localparam logic [DT_W-1:0] ONE = DT_W'(1);

    ph_state_t       state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A dead interval aborts straight back to the side that was on if raw reverts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = OFF;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d = DEAD_L;
                    cnt_d   = dt - ONE;
                end
                LO_ON: begin
                    if (raw) begin
                        state_d = DEAD_H;
                        cnt_d   = dt - ONE;
                    end
                end
                HI_ON: begin
                    if (!raw) begin
                        state_d = DEAD_L;
                        cnt_d   = dt - ONE;
                    end
                end
                DEAD_H: begin
                    if (!raw)              state_d = LO_ON;
                    else if (cnt_q == '0)  state_d = HI_ON;
                    else                   cnt_d   = cnt_q - ONE;
                end
                DEAD_L: begin
                    if (raw)               state_d = HI_ON;
                    else if (cnt_q == '0)  state_d = LO_ON;
                    else                   cnt_d   = cnt_q - ONE;
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_comb begin
        hi = (state_q == HI_ON);
        lo = (state_q == LO_ON);
    end

endmodule

// File: rtl/ac_motor_pwm_deadtime.sv
// N-phase carrier comparator feeding per-phase dead-time gate drivers.
// Optional fault latch enabled by defining AC_MOTOR_PWM_FAULT_EN.
module ac_motor_pwm_deadtime
    import ac_motor_pkg::*;
#(
    parameter int N_PH = N_PH_DEF,
    parameter int DW   = DW_DEF,
    parameter int DT_W = DT_W_DEF
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 lock,
    input  logic [DT_W-1:0]      dead_time,
    input  logic signed [DW-1:0] carrier,
    input  logic [N_PH*DW-1:0]   refs,
`ifdef AC_MOTOR_PWM_FAULT_EN
    input  logic                 fault,
    input  logic                 fault_clr,
    output logic                 fault_latched,
`endif
    output logic [N_PH-1:0]      pwm_hi,
    output logic [N_PH-1:0]      pwm_lo,
    output logic [N_PH-1:0]      pwm_raw
);

    logic [DT_W-1:0] dt_q;
    logic            gate_en;

    // Dead time only changes at a carrier period start; zero is treated as one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dt_q <= DT_W'(1);
        else if (lock)
            dt_q <= (dead_time == '0) ? DT_W'(1) : dead_time;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_raw <= '0;
        end else begin
            for (int i = 0; i < N_PH; i++)
                pwm_raw[i] <= ($signed(refs[i*DW +: DW]) > carrier);
        end
    end

`ifdef AC_MOTOR_PWM_FAULT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault_latched <= 1'b0;
        else if (fault)
            fault_latched <= 1'b1;
        else if (fault_clr)
            fault_latched <= 1'b0;
    end

    assign gate_en = enable & ~fault_latched;
`else
    assign gate_en = enable;
`endif

    for (genvar g = 0; g < N_PH; g++) begin : g_ch
        ac_motor_deadtime_ch #(
            .DT_W (DT_W)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .en  (gate_en),
            .raw (pwm_raw[g]),
            .dt  (dt_q),
            .hi  (pwm_hi[g]),
            .lo  (pwm_lo[g])
        );
    end

endmodule
